// File: rtl/mem_ctrl_if.sv
// Client and RAM bus signals of the memory controller.
// The controller takes the slave view; the surrounding pipeline/RAM takes the master view.
interface mem_ctrl_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [2:0]          mem_rw;
    logic [3:0]          mem_quantity;
    logic [DATA_LEN-1:0] mem_rdata;
    logic [1:0]          mem_status;
    logic [ADDR_LEN-1:0] if_addr;
    logic                if_req;
    logic                if_flush;
    logic [DATA_LEN-1:0] if_rdata;
    logic [1:0]          if_status;
    logic [7:0]          ram_din;
    logic [7:0]          ram_dout;
    logic [ADDR_LEN-1:0] ram_a;
    logic                ram_wr;

    modport master (
        output mem_addr, mem_wdata, mem_rw, mem_quantity,
        input  mem_rdata, mem_status,
        output if_addr, if_req, if_flush,
        input  if_rdata, if_status,
        output ram_din,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rw, mem_quantity,
        output mem_rdata, mem_status,
        input  if_addr, if_req, if_flush,
        output if_rdata, if_status,
        input  ram_din,
        output ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: MEM and IF clients share one byte-wide RAM bus,
// MEM has priority, every transaction issues exactly one RAM access per byte.
module mem_ctrl #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input logic      clk,
    input logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [2:0] RW_READ  = 3'b001;
    localparam logic [2:0] RW_WRITE = 3'b010;
    localparam logic       OWN_MEM  = 1'b0;
    localparam logic       OWN_IF   = 1'b1;

    function automatic logic [2:0] quantity_bytes(input logic [3:0] q);
        case (q)
            4'd1:    return 3'd1;
            4'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_LEN-1:0] rbuf_q, rbuf_d;
    logic [DATA_LEN-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_LEN-1:0] if_rdata_q, if_rdata_d;
    logic [1:0]          mem_status_q, mem_status_d;
    logic [1:0]          if_status_q, if_status_d;
    logic [ADDR_LEN-1:0] ram_a_q, ram_a_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic [1:0]          own_status;
    logic [2:0]          cnt_nx;
    logic [2:0]          byte_idx;

    // Outputs are computed one cycle ahead: cnt_q counts the active cycle (0 = C1).
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        mem_rdata_d = mem_rdata_q;
        if_rdata_d  = if_rdata_q;
        ram_a_d     = '0;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        own_status  = ST_IDLE;
        cnt_nx      = cnt_q + 3'd1;
        byte_idx    = cnt_q - 3'd1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_rw == RW_READ || bus.mem_rw == RW_WRITE) begin
                    owner_d    = OWN_MEM;
                    addr_d     = bus.mem_addr;
                    wdata_d    = bus.mem_wdata;
                    n_d        = quantity_bytes(bus.mem_quantity);
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    ram_a_d    = bus.mem_addr;
                    own_status = ST_BUSY;
                    if (bus.mem_rw == RW_WRITE) begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = bus.mem_wdata[7:0];
                    end else begin
                        state_d = S_READ;
                    end
                end else if (bus.if_req && !bus.if_flush) begin
                    owner_d    = OWN_IF;
                    addr_d     = bus.if_addr;
                    n_d        = 3'd4;
                    cnt_d      = '0;
                    rbuf_d     = '0;
                    ram_a_d    = bus.if_addr;
                    own_status = ST_BUSY;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (owner_q == OWN_IF && bus.if_flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Byte k comes back one cycle after its address went out.
                    if (cnt_q != 3'd0) rbuf_d[8*byte_idx +: 8] = bus.ram_din;
                    cnt_d = cnt_nx;
                    if (cnt_q == n_q) begin
                        state_d    = S_DONE;
                        own_status = ST_DONE;
                        if (owner_q == OWN_MEM) mem_rdata_d = rbuf_d;
                        else                    if_rdata_d  = rbuf_d;
                    end else begin
                        own_status = ST_BUSY;
                        if (cnt_nx < n_q) ram_a_d = addr_q + ADDR_LEN'(cnt_nx);
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_nx;
                if (cnt_nx == n_q) begin
                    state_d    = S_DONE;
                    own_status = ST_DONE;
                end else begin
                    own_status = ST_BUSY;
                    ram_a_d    = addr_q + ADDR_LEN'(cnt_nx);
                    ram_dout_d = wdata_q[8*cnt_nx +: 8];
                    ram_wr_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_status_d = (owner_d == OWN_MEM) ? own_status : ST_IDLE;
        if_status_d  = (owner_d == OWN_IF)  ? own_status : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_MEM;
            mem_status_q <= ST_IDLE;
            if_status_q  <= ST_IDLE;
            mem_rdata_q  <= '0;
            if_rdata_q   <= '0;
            ram_a_q      <= '0;
            ram_dout_q   <= '0;
            ram_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_status_q <= mem_status_d;
            if_status_q  <= if_status_d;
            mem_rdata_q  <= mem_rdata_d;
            if_rdata_q   <= if_rdata_d;
            ram_a_q      <= ram_a_d;
            ram_dout_q   <= ram_dout_d;
            ram_wr_q     <= ram_wr_d;
        end
    end

    // Request context is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        n_q     <= n_d;
        cnt_q   <= cnt_d;
        rbuf_q  <= rbuf_d;
    end

    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_status = mem_status_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_status  = if_status_q;
    assign bus.ram_a      = ram_a_q;
    assign bus.ram_dout   = ram_dout_q;
    assign bus.ram_wr     = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, transaction-level reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic load;
    logic chk_en;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    bit [7:0] ram [0:262143];

    mem_ctrl_if bus ();
    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous byte RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        if (load) begin
            ram[18'h00100] <= 8'h11; ram[18'h00101] <= 8'h22;
            ram[18'h00102] <= 8'h33; ram[18'h00103] <= 8'h44;
            ram[18'h00200] <= 8'hA0; ram[18'h00201] <= 8'hA1;
            ram[18'h00202] <= 8'hA2; ram[18'h00203] <= 8'hA3;
            ram[18'h00000] <= 8'h13; ram[18'h00001] <= 8'h01;
            ram[18'h00002] <= 8'h01; ram[18'h00003] <= 8'hFF;
            ram[18'h00004] <= 8'h93; ram[18'h00005] <= 8'h02;
            ram[18'h00006] <= 8'h10; ram[18'h00007] <= 8'h00;
            ram[18'h30000] <= 8'h5A; ram[18'h00080] <= 8'hF0;
            ram[18'h00400] <= 8'h10; ram[18'h00401] <= 8'h11;
            ram[18'h00402] <= 8'h12; ram[18'h00403] <= 8'h13;
        end else begin
            bus.ram_din <= ram[bus.ram_a[17:0]];
            if (bus.ram_wr) ram[bus.ram_a[17:0]] <= bus.ram_dout;
            if (bus.ram_a == 32'h0003_0000) acc_cnt++;
        end
    end

    // Reference model: one transaction, tracked as cycles elapsed since its accept cycle.
    logic        m_act = 1'b0;
    logic        m_own_if, m_wr;
    logic [31:0] m_addr, m_wdata, m_pend;
    logic [31:0] e_mem_rdata = '0, e_if_rdata = '0;
    int          m_n, m_d, m_last;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; e_mem_rdata = '0; e_if_rdata = '0;
        end else if (m_act) begin
            m_last = m_wr ? m_n + 1 : m_n + 2;
            if (m_own_if && bus.if_flush && m_d <= m_n + 1) m_act = 1'b0;
            else if (m_d == m_last) m_act = 1'b0;
            else begin
                m_d++;
                if (m_d == m_last && !m_wr) begin
                    if (m_own_if) e_if_rdata = m_pend;
                    else          e_mem_rdata = m_pend;
                end
            end
        end else if (bus.mem_rw == 3'b001 || bus.mem_rw == 3'b010) begin
            m_act = 1'b1; m_own_if = 1'b0; m_wr = (bus.mem_rw == 3'b010);
            m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_d = 1;
            m_n = (bus.mem_quantity == 4'd1) ? 1 : (bus.mem_quantity == 4'd2) ? 2 : 4;
            m_pend = '0;
            for (int k = 0; k < m_n; k++) m_pend[8*k +: 8] = ram[18'(m_addr + 32'(k))];
        end else if (bus.if_req && !bus.if_flush) begin
            m_act = 1'b1; m_own_if = 1'b1; m_wr = 1'b0;
            m_addr = bus.if_addr; m_n = 4; m_d = 1;
            m_pend = '0;
            for (int k = 0; k < 4; k++) m_pend[8*k +: 8] = ram[18'(m_addr + 32'(k))];
        end
    end

    always @(negedge clk) begin
        logic [1:0]  e_ms, e_is, st;
        logic [31:0] e_a;
        logic        e_wr;
        logic [7:0]  e_do;
        int          last;
        if (chk_en) begin
            e_ms = 2'b00; e_is = 2'b00; e_a = '0; e_wr = 1'b0; e_do = '0;
            if (m_act) begin
                last = m_wr ? m_n + 1 : m_n + 2;
                st = (m_d == last) ? 2'b10 : 2'b01;
                if (m_own_if) e_is = st;
                else          e_ms = st;
                if (m_d <= m_n) begin
                    e_a  = m_addr + 32'(m_d - 1);
                    e_wr = m_wr;
                    e_do = m_wdata[8*(m_d-1) +: 8];
                end
            end
            chk("cyc_ram_a", bus.ram_a, e_a);
            chk("cyc_ram_wr", 32'(bus.ram_wr), 32'(e_wr));
            if (e_wr) chk("cyc_ram_dout", 32'(bus.ram_dout), 32'(e_do));
            chk("cyc_mem_status", 32'(bus.mem_status), 32'(e_ms));
            chk("cyc_if_status", 32'(bus.if_status), 32'(e_is));
            chk("cyc_mem_rdata", bus.mem_rdata, e_mem_rdata);
            chk("cyc_if_rdata", bus.if_rdata, e_if_rdata);
        end
    end

    initial begin
        rst = 1'b1; load = 1'b1; chk_en = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_rw = '0; bus.mem_quantity = '0;
        bus.if_addr = '0; bus.if_req = 1'b0; bus.if_flush = 1'b0;
        tick(); load = 1'b0;
        repeat (2) tick();
        rst = 1'b0; chk_en = 1'b1;
        chk("rst_mem_status", 32'(bus.mem_status), 32'h0);
        chk("rst_if_status", 32'(bus.if_status), 32'h0);
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);

        // MEM word read of 0x100
        bus.mem_addr = 32'h100; bus.mem_quantity = 4'd4; bus.mem_rw = 3'b001;
        tick(); bus.mem_rw = 3'b000;
        chk("rd_c1_ram_a", bus.ram_a, 32'h100);
        chk("rd_c1_status", 32'(bus.mem_status), 32'h1);
        repeat (3) tick();
        chk("rd_c4_ram_a", bus.ram_a, 32'h103);
        repeat (2) tick();
        chk("rd_c6_status", 32'(bus.mem_status), 32'h2);
        chk("rd_c6_rdata", bus.mem_rdata, 32'h4433_2211);
        tick();
        chk("rd_c7_status", 32'(bus.mem_status), 32'h0);

        // MEM half write of 0x200
        bus.mem_addr = 32'h200; bus.mem_quantity = 4'd2; bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_rw = 3'b010;
        tick(); bus.mem_rw = 3'b000;
        chk("wr_c1_wr", 32'(bus.ram_wr), 32'h1);
        chk("wr_c1_a", bus.ram_a, 32'h200);
        chk("wr_c1_dout", 32'(bus.ram_dout), 32'hEF);
        tick();
        chk("wr_c2_a", bus.ram_a, 32'h201);
        chk("wr_c2_dout", 32'(bus.ram_dout), 32'hBE);
        tick();
        chk("wr_c3_status", 32'(bus.mem_status), 32'h2);
        chk("wr_ram200", 32'(ram[18'h200]), 32'hEF);
        chk("wr_ram201", 32'(ram[18'h201]), 32'hBE);
        chk("wr_ram202", 32'(ram[18'h202]), 32'hA2);
        tick();

        // Simultaneous IF fetch and MEM byte read of an IO address
        acc_cnt = 0;
        bus.mem_addr = 32'h3_0000; bus.mem_quantity = 4'd1; bus.mem_rw = 3'b001;
        bus.if_addr = 32'h4; bus.if_req = 1'b1;
        tick(); bus.mem_rw = 3'b000;
        chk("arb_c1_mem", 32'(bus.mem_status), 32'h1);
        chk("arb_c1_if", 32'(bus.if_status), 32'h0);
        repeat (2) tick();
        chk("arb_c3_mem", 32'(bus.mem_status), 32'h2);
        chk("arb_c3_rdata", bus.mem_rdata, 32'h0000_005A);
        chk("arb_c3_if", 32'(bus.if_status), 32'h0);
        tick();
        chk("arb_c4_if", 32'(bus.if_status), 32'h0);
        tick(); bus.if_req = 1'b0;
        chk("arb_c5_if", 32'(bus.if_status), 32'h1);
        chk("arb_io_accesses", 32'(acc_cnt), 32'd1);
        repeat (5) tick();
        chk("arb_c10_if", 32'(bus.if_status), 32'h2);
        chk("arb_c10_rdata", bus.if_rdata, 32'h0010_0293);
        tick();

        // if_flush in IDLE suppresses the fetch
        bus.if_addr = 32'h100; bus.if_req = 1'b1; bus.if_flush = 1'b1;
        tick(); bus.if_req = 1'b0; bus.if_flush = 1'b0;
        chk("idle_flush_if", 32'(bus.if_status), 32'h0);
        tick();

        // IF fetch at 0x0 aborted in C3
        bus.if_addr = 32'h0; bus.if_req = 1'b1;
        tick(); bus.if_req = 1'b0;
        repeat (2) tick();
        bus.if_flush = 1'b1;
        tick(); bus.if_flush = 1'b0;
        chk("fl_c4_if", 32'(bus.if_status), 32'h0);
        chk("fl_c4_rdata", bus.if_rdata, 32'h0010_0293);
        chk("fl_c4_wr", 32'(bus.ram_wr), 32'h0);
        repeat (2) tick();
        chk("fl_c6_if", 32'(bus.if_status), 32'h0);
        tick();

        // Reset during a word write
        bus.mem_addr = 32'h400; bus.mem_quantity = 4'd4; bus.mem_wdata = 32'hCAFE_F00D; bus.mem_rw = 3'b010;
        tick(); bus.mem_rw = 3'b000; rst = 1'b1;
        tick();
        tick(); rst = 1'b0;
        chk("rw_c3_wr", 32'(bus.ram_wr), 32'h0);
        chk("rw_c3_mem", 32'(bus.mem_status), 32'h0);
        chk("rw_c3_if", 32'(bus.if_status), 32'h0);
        chk("rw_c3_mrdata", bus.mem_rdata, 32'h0);
        chk("rw_c3_irdata", bus.if_rdata, 32'h0);
        chk("rw_ram400", 32'(ram[18'h400]), 32'h0D);
        chk("rw_ram401", 32'(ram[18'h401]), 32'h11);
        chk("rw_ram403", 32'(ram[18'h403]), 32'h13);
        tick();

        // MEM byte read, zero-extended
        bus.mem_addr = 32'h80; bus.mem_quantity = 4'd1; bus.mem_rw = 3'b001;
        tick(); bus.mem_rw = 3'b000;
        repeat (2) tick();
        chk("b_c3_status", 32'(bus.mem_status), 32'h2);
        chk("b_c3_rdata", bus.mem_rdata, 32'h0000_00F0);
        tick();
        chk("b_c4_status", 32'(bus.mem_status), 32'h0);

        // Quantity 0 is treated as a word
        bus.mem_addr = 32'h100; bus.mem_quantity = 4'd0; bus.mem_rw = 3'b001;
        tick(); bus.mem_rw = 3'b000;
        repeat (5) tick();
        chk("q0_c6_status", 32'(bus.mem_status), 32'h2);
        chk("q0_c6_rdata", bus.mem_rdata, 32'h4433_2211);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
